// File: rtl/mem_port_arbiter_pkg.sv
// Shared helper functions for the memory port arbiter.
// Only width and index arithmetic lives here; the block itself is sized by parameters.
package mem_port_arbiter_pkg;

   // Width of a pointer that can address n requesters (never narrower than 1 bit).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Index following idx in a ring of n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first valid requester at or after the
// pointer, wrapping from the highest index back to 0. Purely combinational.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_grant_idx
);

   logic found;

   // Search upper segment [ptr, NUM_REQ-1] first, then the wrapped segment [0, ptr-1].
   // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      found       = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && i_valid[i] && (i >= int'(i_ptr))) begin
            o_grant[i]  = 1'b1;
            o_grant_idx = PTR_W'(i);
            found       = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && i_valid[i] && (i < int'(i_ptr))) begin
            o_grant[i]  = 1'b1;
            o_grant_idx = PTR_W'(i);
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port registered-output memory between NUM_REQ requesters.
// One access per cycle, round-robin fair; reads answer one cycle after the grant.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int NUM_ENTRIES = 64,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ-1:0]              i_req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wdata,
   output logic [NUM_REQ-1:0]              o_req_ready,
   output logic [NUM_REQ-1:0]              o_rsp_valid,
   output logic [DATA_WIDTH-1:0]           o_rsp_data,
   output logic                            o_mem_cenb,
   output logic                            o_mem_wenb,
   output logic [ADDR_WIDTH-1:0]           o_mem_addr,
   output logic [DATA_WIDTH-1:0]           o_mem_wdata,
   input  logic [DATA_WIDTH-1:0]           i_mem_rdata
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   // Elaboration-time sanity checks on the parameter set.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("mem_port_arbiter: NUM_REQ must be in 2..8");
   end
   if (NUM_ENTRIES > (2 ** ADDR_WIDTH)) begin : g_bad_addr_width
      $error("mem_port_arbiter: ADDR_WIDTH too narrow for NUM_ENTRIES");
   end

   logic [PTR_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] rr_grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic [NUM_REQ-1:0] rd_tag_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .i_valid     (i_req_valid),
      .i_ptr       (ptr_q),
      .o_grant     (rr_grant),
      .o_grant_idx (grant_idx)
   );

   // Nothing is granted while reset is held, so the memory stays idle.
   assign grant       = rst ? '0 : rr_grant;
   assign any_grant   = |grant;
   assign o_req_ready = grant;

   // Route the granted requester onto the memory port; idle values when nobody wins.
   always_comb begin
      o_mem_wenb  = 1'b1;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            o_mem_wenb  = ~i_req_write[i];
            o_mem_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_mem_cenb = ~any_grant;

   // Advance the round-robin pointer past the winner; hold it on idle cycles.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (any_grant) begin
         ptr_q <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
      end
   end

   // Remember which requester issued a read; the memory answers next cycle.
   // Asynchronous clear drops any read in flight when reset hits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_tag_q <= '0;
      end else begin
         rd_tag_q <= grant & ~i_req_write;
      end
   end

   assign o_rsp_valid = rd_tag_q;
   // NOTE: memory contents are not reset here; the array owns its own initialisation.
   assign o_rsp_data  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model (pointer, memory array,
// pending response) that follows the arbitration rules directly.
module tb_mem_port_arbiter;

   localparam int NR = 2;
   localparam int AW = 6;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_write = '0;
   logic [NR*AW-1:0]  req_addr  = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              mem_cenb;
   logic              mem_wenb;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   // Second instance with three requesters for the wrap-around scenario.
   logic [2:0]        r3_valid = '0;
   logic [2:0]        r3_write = '0;
   logic [3*AW-1:0]   r3_addr  = '0;
   logic [3*DW-1:0]   r3_wdata = '0;
   logic [2:0]        r3_ready;
   logic [2:0]        r3_rsp_valid;
   logic [DW-1:0]     r3_rsp_data;
   logic              r3_cenb;
   logic              r3_wenb;
   logic [AW-1:0]     r3_mem_addr;
   logic [DW-1:0]     r3_mem_wdata;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .i_req_write (req_write),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_data  (rsp_data),
      .o_mem_cenb  (mem_cenb),
      .o_mem_wenb  (mem_wenb),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   mem_port_arbiter #(.NUM_REQ(3)) dut3 (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (r3_valid),
      .i_req_write (r3_write),
      .i_req_addr  (r3_addr),
      .i_req_wdata (r3_wdata),
      .o_req_ready (r3_ready),
      .o_rsp_valid (r3_rsp_valid),
      .o_rsp_data  (r3_rsp_data),
      .o_mem_cenb  (r3_cenb),
      .o_mem_wenb  (r3_wenb),
      .o_mem_addr  (r3_mem_addr),
      .o_mem_wdata (r3_mem_wdata),
      .i_mem_rdata ('0)
   );

   // Behavioural single-port memory with registered read data.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (!mem_cenb) begin
         if (!mem_wenb) mem[mem_addr] <= mem_wdata;
         else           mem_rdata     <= mem[mem_addr];
      end
   end

   // Reference model state.
   int            n_tests = 0;
   int            n_fail  = 0;
   int            m_ptr   = 0;
   logic [DW-1:0] m_mem   [64];
   bit   [63:0]   m_known = '0;
   logic [NR-1:0] m_rsp_valid = '0;
   logic [DW-1:0] m_rsp_data  = '0;
   bit            m_rsp_chk   = 1'b0;
   int            grant_cnt [NR];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit w, input int a, input int d);
      req_valid[i]             = v;
      req_write[i]             = w;
      req_addr[i*AW +: AW]     = AW'(a);
      req_wdata[i*DW +: DW]    = DW'(d);
   endtask

   // One clock of traffic: inputs are already applied; check at the falling edge,
   // then advance the model to what the next cycle must show.
   task automatic run_cycle();
      int            g;
      logic [NR-1:0] exp_gnt;
      int            a;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NR; k++) begin
         if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      check("ready", req_ready, exp_gnt);
      check("cenb", mem_cenb, (g < 0));
      if (g >= 0) begin
         check("wenb", mem_wenb, !req_write[g]);
         check("addr", mem_addr, req_addr[g*AW +: AW]);
         check("wdata", mem_wdata, req_wdata[g*DW +: DW]);
      end else begin
         check("idle_wenb", mem_wenb, 1);
         check("idle_addr", mem_addr, 0);
         check("idle_wdata", mem_wdata, 0);
      end
      check("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid != 0 && m_rsp_chk) check("rsp_data", rsp_data, m_rsp_data);
      m_rsp_valid = '0;
      m_rsp_chk   = 1'b0;
      if (g >= 0) begin
         grant_cnt[g]++;
         a = int'(req_addr[g*AW +: AW]);
         if (req_write[g]) begin
            m_mem[a]   = req_wdata[g*DW +: DW];
            m_known[a] = 1'b1;
         end else begin
            m_rsp_valid[g] = 1'b1;
            m_rsp_data     = m_mem[a];
            m_rsp_chk      = m_known[a];
         end
         m_ptr = (g + 1) % NR;
      end
      @(posedge clk);
      #1;
   endtask

   // Hold reset for a cycle with requests pending; nothing may be granted or answered.
   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_write = '0;
      m_ptr       = 0;
      m_rsp_valid = '0;
      m_rsp_chk   = 1'b0;
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cenb", mem_cenb, 1);
      check("rst_wenb", mem_wenb, 1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = '0;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NR; i++) set_req(i, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
      @(posedge clk);
      #1;
      do_reset();

      // Single requester: write then read back.
      idle_all();
      set_req(0, 1, 1, 5, 'h1234);
      run_cycle();
      set_req(0, 1, 0, 5, 0);
      run_cycle();
      idle_all();
      check("single_rsp_expected", m_rsp_valid, 2'b01);
      run_cycle();

      // Contention from reset: both reading every cycle, strict alternation.
      do_reset();
      for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
      for (int c = 0; c < 8; c++) begin
         set_req(0, 1, 0, c, 0);
         set_req(1, 1, 0, 63 - c, 0);
         run_cycle();
      end
      check("contend_cnt0", grant_cnt[0], 4);
      check("contend_cnt1", grant_cnt[1], 4);
      idle_all();
      run_cycle();

      // Write followed immediately by read of the same address.
      set_req(1, 1, 1, 63, 'hBEEF);
      run_cycle();
      set_req(1, 1, 0, 63, 0);
      run_cycle();
      idle_all();
      check("wtr_model", m_rsp_data, 'hBEEF);
      run_cycle();

      // Idle stretch, then both valid: winner must follow the held pointer.
      for (int c = 0; c < 5; c++) run_cycle();
      set_req(0, 1, 0, 1, 0);
      set_req(1, 1, 0, 2, 0);
      run_cycle();
      idle_all();
      run_cycle();

      // Reset the cycle after a read grant; pointer was moved off 0 beforehand.
      set_req(0, 1, 0, 5, 0);
      run_cycle();
      do_reset();
      set_req(0, 1, 0, 7, 0);
      set_req(1, 1, 0, 8, 0);
      run_cycle();
      idle_all();
      run_cycle();

      // Randomized mixed traffic on a small address window.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
         end
         run_cycle();
      end
      idle_all();
      run_cycle();

      // Three-requester wrap: 2 alone, then 0 and 2 -> 2, 0, 2.
      r3_valid = 3'b100;
      r3_addr[2*AW +: AW] = AW'(9);
      @(negedge clk);
      check("wrap_g2", r3_ready, 3'b100);
      check("wrap_cenb", r3_cenb, 0);
      check("wrap_addr", r3_mem_addr, 9);
      @(posedge clk);
      #1;
      r3_valid = 3'b101;
      @(negedge clk);
      check("wrap_g0", r3_ready, 3'b001);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wrap_g2b", r3_ready, 3'b100);
      @(posedge clk);
      #1;
      r3_valid = '0;
      @(negedge clk);
      check("wrap_idle", r3_cenb, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
